// File: rtl/uart_pkg.sv
// Shared types and divisor helpers for the UART echo responder.
// Line-rate constants are derived from clock and baud parameters.
package uart_pkg;

  localparam int OS_RATE = 16;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  function automatic int os_div(
    input int clk_hz,
    input int baud
  );
    return clk_hz / (baud * OS_RATE);
  endfunction

  function automatic int cpb(
    input int clk_hz,
    input int baud
  );
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_resp_fifo.sv
// Synchronous response FIFO; a push while full only lands
// when a pop frees the slot in the same cycle.
module uart_resp_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic [W-1:0]           i_din,
  input  logic                   i_pop,
  output logic [W-1:0]           o_dout,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [LW-1:0] r_level;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_level == LW'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_dout    = r_mem[r_rd];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr] <= i_din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + AW'(1);
      if (w_do_pop)  r_rd <= r_rd + AW'(1);
      if (w_do_push && !w_do_pop)
        r_level <= r_level + LW'(1);
      else if (w_do_pop && !w_do_push)
        r_level <= r_level - LW'(1);
    end
  end

endmodule

// File: rtl/uart_echo_responder.sv
// Far-end responder: receives 8N1 bytes, queues them
// XOR-masked, and transmits the responses back as 8N1.
module uart_echo_responder
  import uart_pkg::*;
#(
  parameter int          CLK_FREQ   = 50000000,
  parameter int          BAUD_RATE  = 115200,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [7:0]  RESP_XOR   = 8'hFF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rxd,
  input  logic                        tx_en,
  output logic                        txd,
  output logic                        tx_busy,
  output logic [7:0]                  rx_data,
  output logic                        rx_valid,
  output logic                        frame_err,
  output logic                        overrun,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int OSD   = os_div(CLK_FREQ, BAUD_RATE);
  localparam int CPB_N = cpb(CLK_FREQ, BAUD_RATE);
  localparam int OW    = $clog2(OSD + 1);
  localparam int TW    = $clog2(CPB_N + 1);

  logic [OW-1:0] r_os_cnt;
  logic          w_tick;
  logic [1:0]    r_sync;
  logic          w_rxd;

  assign w_tick = (r_os_cnt == OW'(OSD - 1));
  assign w_rxd  = r_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_os_cnt <= '0;
      r_sync   <= 2'b11;
    end else begin
      r_os_cnt <= w_tick ? '0 : r_os_cnt + OW'(1);
      r_sync   <= {r_sync[0], rxd};
    end
  end

  rx_state_t  r_rx_state, w_rx_nxt;
  logic [3:0] r_rx_tcnt, w_tcnt_nxt;
  logic [2:0] r_rx_bit, w_bit_nxt;
  logic [7:0] r_rx_sh, w_sh_nxt;
  logic       w_good, w_bad;
  logic [7:0] r_rx_data;
  logic       r_rx_valid;
  logic       r_frame_err;

  always_comb begin
    w_rx_nxt   = r_rx_state;
    w_tcnt_nxt = r_rx_tcnt;
    w_bit_nxt  = r_rx_bit;
    w_sh_nxt   = r_rx_sh;
    w_good     = 1'b0;
    w_bad      = 1'b0;
    if (w_tick) begin
      w_tcnt_nxt = r_rx_tcnt + 4'd1;
      unique case (r_rx_state)
        RX_IDLE: begin
          w_tcnt_nxt = '0;
          if (!w_rxd) w_rx_nxt = RX_START;
        end
        RX_START: if (r_rx_tcnt == 4'd7) begin
          w_tcnt_nxt = '0;
          w_bit_nxt  = '0;
          w_rx_nxt   = w_rxd ? RX_IDLE : RX_DATA;
        end
        RX_DATA: if (r_rx_tcnt == 4'd15) begin
          w_sh_nxt  = {w_rxd, r_rx_sh[7:1]};
          w_bit_nxt = r_rx_bit + 3'd1;
          if (r_rx_bit == 3'd7) w_rx_nxt = RX_STOP;
        end
        RX_STOP: if (r_rx_tcnt == 4'd15) begin
          w_good   = w_rxd;
          w_bad    = !w_rxd;
          w_rx_nxt = w_rxd ? RX_IDLE : RX_BREAK;
        end
        RX_BREAK: if (w_rxd) w_rx_nxt = RX_IDLE;
        default: w_rx_nxt = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_state  <= RX_IDLE;
      r_rx_tcnt   <= '0;
      r_rx_bit    <= '0;
      r_rx_sh     <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_state  <= w_rx_nxt;
      r_rx_tcnt   <= w_tcnt_nxt;
      r_rx_bit    <= w_bit_nxt;
      r_rx_sh     <= w_sh_nxt;
      r_rx_valid  <= w_good;
      r_frame_err <= w_bad;
      if (w_good) r_rx_data <= r_rx_sh;
    end
  end

  // The push rides on the registered rx_valid pulse
  logic [7:0] w_dout;
  logic       w_full;
  logic       w_empty;
  logic       w_pop;
  logic       r_overrun;

  uart_resp_fifo #(
    .DEPTH(FIFO_DEPTH),
    .W    (8)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_push (r_rx_valid),
    .i_din  (r_rx_data ^ RESP_XOR),
    .i_pop  (w_pop),
    .o_dout (w_dout),
    .o_full (w_full),
    .o_empty(w_empty),
    .o_level(fifo_level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_overrun <= 1'b0;
    else if (r_rx_valid && w_full && !w_pop)
      r_overrun <= 1'b1;
  end

  tx_state_t     r_tx_state, w_tx_nxt;
  logic [TW-1:0] r_tx_cnt;
  logic [2:0]    r_tx_bit;
  logic [7:0]    r_tx_sh;
  logic          w_tend;

  assign w_tend = (r_tx_cnt == TW'(CPB_N - 1));

  always_comb begin
    w_tx_nxt = r_tx_state;
    w_pop    = 1'b0;
    unique case (r_tx_state)
      TX_IDLE: if (tx_en && !w_empty) begin
        w_pop    = 1'b1;
        w_tx_nxt = TX_START;
      end
      TX_START: if (w_tend) w_tx_nxt = TX_DATA;
      TX_DATA: if (w_tend && r_tx_bit == 3'd7)
        w_tx_nxt = TX_STOP;
      TX_STOP: if (w_tend) w_tx_nxt = TX_IDLE;
      default: w_tx_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_sh    <= '0;
    end else begin
      r_tx_state <= w_tx_nxt;
      if (w_tend || w_tx_nxt != r_tx_state ||
          r_tx_state == TX_IDLE)
        r_tx_cnt <= '0;
      else
        r_tx_cnt <= r_tx_cnt + TW'(1);
      if (w_pop) begin
        r_tx_sh  <= w_dout;
        r_tx_bit <= '0;
      end else if (r_tx_state == TX_DATA && w_tend) begin
        r_tx_sh  <= {1'b1, r_tx_sh[7:1]};
        r_tx_bit <= r_tx_bit + 3'd1;
      end
    end
  end

  assign txd = (r_tx_state == TX_START) ? 1'b0 :
               (r_tx_state == TX_DATA)  ? r_tx_sh[0] :
                                          1'b1;
  assign tx_busy   = (r_tx_state != TX_IDLE);
  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_echo_responder.sv
// Scoreboard bench for the UART echo responder at a
// reduced clock so one bit is 128 clocks.
module tb_uart_echo_responder;

  localparam int CPB = 128;
  localparam int OSD = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic       tx_en = 1'b0;
  logic       txd, tx_busy, rx_valid;
  logic       frame_err, overrun;
  logic [7:0] rx_data;
  logic [2:0] fifo_level;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  int ferr_cnt = 0;
  int rxv_cnt = 0;
  int max_level = 0;
  int busy_seen = 0;

  always #5 clk = ~clk;

  uart_echo_responder #(
    .CLK_FREQ  (14745600),
    .BAUD_RATE (115200),
    .FIFO_DEPTH(4),
    .RESP_XOR  (8'hFF)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rxd       (rxd),
    .tx_en     (tx_en),
    .txd       (txd),
    .tx_busy   (tx_busy),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .fifo_level(fifo_level)
  );

  function automatic void check(
    input string name,
    input int    act,
    input int    exp
  );
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid) begin
        rxv_cnt++;
        if (rxq.size() == 0)
          check("rx_unexpected", rx_data, 256);
        else
          check("rx_data", rx_data, rxq.pop_front());
      end
      if (frame_err) ferr_cnt++;
      if (fifo_level > max_level) max_level = fifo_level;
      if (tx_busy) busy_seen++;
    end
  end

  int bcnt = 0;
  always @(negedge clk) begin
    if (!rst_n) bcnt = 0;
    else if (tx_busy) bcnt++;
    else if (bcnt != 0) begin
      check("tx_busy_len", bcnt, 10 * CPB);
      bcnt = 0;
    end
  end

  int         tcnt = 0;
  bit         tact = 0;
  logic [9:0] tfr;
  always @(negedge clk) begin
    if (!rst_n) tact = 0;
    else if (!tact) begin
      if (!txd) begin
        tact = 1;
        tcnt = 0;
        check("busy_at_start", tx_busy, 1);
      end
    end else begin
      tcnt++;
      if (tcnt % CPB == CPB / 2) begin
        tfr[tcnt / CPB] = txd;
        if (tcnt / CPB == 9) begin
          tact = 0;
          check("tx_start_bit", tfr[0], 0);
          check("tx_stop_bit", tfr[9], 1);
          if (txq.size() == 0)
            check("tx_unexpected", tfr[8:1], 256);
          else
            check("tx_data", tfr[8:1], txq.pop_front());
        end
      end
    end
  end

  task automatic send(input logic [7:0] b, input logic stp);
    rxd = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(posedge clk);
    end
    rxd = stp;
    repeat (CPB) @(posedge clk);
    rxd = 1'b1;
  endtask

  task automatic send_good(input logic [7:0] b, input bit acc);
    rxq.push_back(b);
    if (acc) txq.push_back(b ^ 8'hFF);
    send(b, 1'b1);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((txq.size() != 0 || tx_busy || fifo_level != 0)
           && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("drain_in_time", int'(n < budget), 1);
    repeat (4) @(posedge clk);
  endtask

  initial begin
    repeat (200000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_rx, b_fe, n;
    repeat (3) @(posedge clk);
    #1;
    check("rst_txd", txd, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_level", fifo_level, 0);
    @(posedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);

    tx_en = 1'b1;
    send_good(8'hA5, 1);
    wait_drain(30 * CPB);
    check("single_rx_count", rxv_cnt, 1);

    b_rx = rxv_cnt;
    b_fe = ferr_cnt;
    rxd = 1'b0;
    repeat (5 * OSD) @(posedge clk);
    rxd = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    check("glitch_no_rx", rxv_cnt, b_rx);
    check("glitch_no_ferr", ferr_cnt, b_fe);
    send_good(8'h69, 1);
    wait_drain(30 * CPB);

    b_rx = rxv_cnt;
    b_fe = ferr_cnt;
    send(8'h3C, 1'b0);
    rxd = 1'b0;
    repeat (2 * CPB) @(posedge clk);
    rxd = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    check("ferr_count", ferr_cnt, b_fe + 1);
    check("ferr_no_rx", rxv_cnt, b_rx);
    check("ferr_no_push", fifo_level, 0);
    check("ferr_no_tx", tx_busy, 0);
    send_good(8'hC3, 1);
    wait_drain(30 * CPB);

    max_level = 0;
    for (int i = 0; i < 16; i++)
      send_good(8'(i), 1);
    wait_drain(40 * CPB);
    check("stream_level_le2", int'(max_level <= 2), 1);
    check("stream_no_overrun", overrun, 0);

    tx_en = 1'b0;
    for (int i = 1; i <= 5; i++)
      send_good(8'(i), i <= 4);
    repeat (CPB) @(posedge clk);
    check("ovr_level", fifo_level, 4);
    check("ovr_flag", overrun, 1);
    check("ovr_idle_tx", tx_busy, 0);
    tx_en = 1'b1;
    wait_drain(60 * CPB);
    check("ovr_sticky", overrun, 1);

    tx_en = 1'b0;
    send_good(8'h22, 1);
    send_good(8'h33, 1);
    repeat (8) @(posedge clk);
    check("pre_rst_level", fifo_level, 2);
    tx_en = 1'b1;
    n = 0;
    while (!tx_busy && n < 20) begin
      @(posedge clk);
      n++;
    end
    check("pre_rst_busy", tx_busy, 1);
    repeat (3 * CPB + 7) @(posedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_txd", txd, 1);
    check("arst_busy", tx_busy, 0);
    repeat (5) @(posedge clk);
    #1;
    check("arst_level", fifo_level, 0);
    check("arst_overrun", overrun, 0);
    check("arst_rx_data", rx_data, 0);
    check("arst_ferr", frame_err, 0);
    txq.delete();
    busy_seen = 0;
    rst_n = 1'b1;
    repeat (12 * CPB) @(posedge clk);
    check("post_rst_no_tx", busy_seen, 0);
    check("post_rst_txd", txd, 1);

    check("txq_empty", txq.size(), 0);
    check("rxq_empty", rxq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
